// File: rtl/restoring_divider_pkg.sv
// Shared types and defaults for the restoring divider.
package restoring_divider_pkg;

    localparam int DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/restoring_divider_sub_stage.sv
// Trial subtraction for one restoring step: WIDTH+1-bit difference and borrow-out.
module div_sub_stage #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] minuend_i,
    input  logic [WIDTH:0] subtrahend_i,
    output logic [WIDTH:0] diff_o,
    output logic           borrow_o
);

    assign {borrow_o, diff_o} = {1'b0, minuend_i} - {1'b0, subtrahend_i};

endmodule

// File: rtl/restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per RUN cycle,
// results registered and held until the next completed operation.
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH:0]   quo_shift;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic             diff_msb_unused;

    // Next dividend bit enters the partial remainder from the quotient MSB.
    assign shifted = {rem_q, quo_q[WIDTH-1]};

    div_sub_stage #(.WIDTH(WIDTH)) u_sub (
        .minuend_i    (shifted),
        .subtrahend_i ({1'b0, dvs_q}),
        .diff_o       (diff),
        .borrow_o     (borrow)
    );

    // On no-borrow the difference is below the divisor, so its MSB is always zero.
    assign diff_msb_unused = diff[WIDTH];
    assign step_rem        = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_shift       = {quo_q, ~borrow};
    assign step_quo        = quo_shift[WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (divisor == '0) begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = RUN;
                        cnt_d   = '0;
                        rem_d   = '0;
                        quo_d   = dividend;
                        dvs_d   = divisor;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d     = DONE;
                    cnt_d       = '0;
                    quotient_d  = step_quo;
                    remainder_d = step_rem;
                    dbz_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench: directed and random 8-bit divisions plus exhaustive 4-bit pairs.
module tb_restoring_divider;

    typedef struct {
        int q;
        int r;
        int z;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, start4;
    logic [7:0] a8, b8, quotient8, remainder8;
    logic [3:0] a4, b4, quotient4, remainder4;
    logic       busy8, done8, dbz8, busy4, done4, dbz4;

    exp_t q8[$];
    exp_t q4[$];
    exp_t prev8 = '{0, 0, 0};
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    restoring_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .dividend(a8), .divisor(b8),
        .busy(busy8), .done(done8), .quotient(quotient8), .remainder(remainder8),
        .div_by_zero(dbz8)
    );

    restoring_divider #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .dividend(a4), .divisor(b4),
        .busy(busy4), .done(done4), .quotient(quotient4), .remainder(remainder4),
        .div_by_zero(dbz4)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference: plain integer division with the divide-by-zero convention.
    function automatic exp_t ref_div(input int a, input int b, input int w);
        exp_t e;
        if (b == 0) e = '{(1 << w) - 1, a, 1};
        else        e = '{a / b, a % b, 0};
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done8) begin
            if (q8.size() == 0) chk("unexpected_done8", 1, 0);
            else begin
                exp_t e;
                e = q8.pop_front();
                chk("quotient8", quotient8, e.q);
                chk("remainder8", remainder8, e.r);
                chk("div_by_zero8", dbz8, e.z);
                prev8 = e;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done4) begin
            if (q4.size() == 0) chk("unexpected_done4", 1, 0);
            else begin
                exp_t e;
                e = q4.pop_front();
                chk("quotient4", quotient4, e.q);
                chk("remainder4", remainder4, e.r);
                chk("div_by_zero4", dbz4, e.z);
            end
        end
    end

    // Call right after a negedge; start is accepted on the next posedge.
    task automatic issue8(input int a, input int b);
        start8 = 1'b1;
        a8 = 8'(a);
        b8 = 8'(b);
        q8.push_back(ref_div(a, b, 8));
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
    endtask

    // Counts negedges after acceptance until done; optionally pulses a 9/9 start mid-run.
    task automatic wait8(input int inj, input int exp_lat, input string nm);
        int lat = 0;
        int nbusy = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1 && exp_lat > 1) chk({nm, "_hold_q_run"}, quotient8, prev8.q);
            if (busy8) nbusy++;
            if (n == inj) begin
                start8 = 1'b1; a8 = 8'd9; b8 = 8'd9;
            end
            if (n == inj + 1) start8 = 1'b0;
            if (done8) begin
                lat = n;
                break;
            end
        end
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_busy_cycles"}, nbusy, exp_lat - 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        #1;
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_quotient", quotient8, 0);
        chk("rst_remainder", remainder8, 0);
        chk("rst_dbz", dbz8, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 100 / 7
        @(negedge clk); issue8(100, 7);
        wait8(-5, 9, "d100_7");
        @(negedge clk);
        chk("done_one_cycle", done8, 0);
        chk("back_to_idle_busy", busy8, 0);

        // 255 / 1 then 5 / 9 with start held through DONE
        @(negedge clk);
        start8 = 1'b1; a8 = 8'd255; b8 = 8'd1;
        q8.push_back(ref_div(255, 1, 8));
        @(posedge clk); #1;
        a8 = 8'd5; b8 = 8'd9;
        q8.push_back(ref_div(5, 9, 8));
        lat = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (done8) begin lat = n; break; end
        end
        chk("b2b_first_latency", lat, 9);
        @(posedge clk); #1;
        start8 = 1'b0;
        @(negedge clk);
        chk("b2b_no_idle_busy", busy8, 1);
        wait8(-5, 8, "b2b_second");

        // 37 / 0
        @(negedge clk); issue8(37, 0);
        wait8(-5, 1, "d37_0");

        // 200 / 3 with an ignored 9/9 start at cycle 3
        @(negedge clk); issue8(200, 3);
        wait8(2, 9, "d200_3_ign");

        // 200 / 3 aborted by reset at cycle 4, then 12 / 4
        @(negedge clk); issue8(200, 3);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        chk("abort_quotient", quotient8, 0);
        chk("abort_remainder", remainder8, 0);
        chk("abort_dbz", dbz8, 0);
        q8.delete();
        prev8 = '{0, 0, 0};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue8(12, 4);
        wait8(-5, 9, "d12_4_after_rst");

        // Random 8-bit operations, some with a zero divisor
        repeat (40) begin
            int a, b;
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            @(negedge clk); issue8(a, b);
            wait8(-5, (b == 0) ? 1 : 9, "rand");
        end

        // Exhaustive 4-bit operand pairs
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                bit seen;
                @(negedge clk);
                start4 = 1'b1; a4 = 4'(a); b4 = 4'(b);
                q4.push_back(ref_div(a, b, 4));
                @(posedge clk); #1;
                start4 = 1'b0;
                a4 = 4'($urandom); b4 = 4'($urandom);
                seen = 1'b0;
                for (int n = 1; n <= 10; n++) begin
                    @(negedge clk);
                    if (done4) begin seen = 1'b1; break; end
                end
                if (!seen) chk("w4_timeout", 0, 1);
            end
        end

        repeat (3) @(negedge clk);
        chk("q8_drained", q8.size(), 0);
        chk("q4_drained", q4.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
